// File: rtl/intc_arb_if.sv
`default_nettype none
// ============================================================================
// intc_arb_if : source, configuration and CPU-handshake bundle for intc_arb
// Rev 1.0
// ============================================================================
interface intc_arb_if #(
  parameter int NSRC = 8
);
  logic [NSRC-1:0] src;
  logic            cfg_we;
  logic [3:0]      cfg_addr;
  logic [7:0]      cfg_wdata;
  logic [7:0]      cfg_rdata;
  logic            intr_req;
  logic [3:0]      intr_level;
  logic [7:0]      intr_vec;
  logic            inta_ack;

  modport slave (
    input  src, cfg_we, cfg_addr, cfg_wdata, inta_ack,
    output cfg_rdata, intr_req, intr_level, intr_vec
  );

  modport master (
    output src, cfg_we, cfg_addr, cfg_wdata, inta_ack,
    input  cfg_rdata, intr_req, intr_level, intr_vec
  );
endinterface
`default_nettype wire

// File: rtl/intc_arb.sv
`default_nettype none
// ============================================================================
// intc_arb : priority interrupt arbiter, level/edge sources, vectored request
// Rev 1.0
// ============================================================================
module intc_arb #(
  parameter int NSRC = 8
) (
  input  logic        clk,
  input  logic        rst,
  intc_arb_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [3:0] ADDR_VBASE = 4'd8;
  localparam logic [3:0] ADDR_PEND  = 4'd9;

  state_t          state_q;
  logic [3:0]      pri_q [NSRC];
  logic [NSRC-1:0] edge_q;
  logic [NSRC-1:0] prev_q;
  logic [NSRC-1:0] pend_q;
  logic [NSRC-1:0] pend_d;
  logic [7:0]      vbase_q;
  logic [7:0]      rdata_q;
  logic [7:0]      rdata_d;
  logic            req_q;
  logic [3:0]      level_q;
  logic [7:0]      vec_q;
  logic [2:0]      cur_q;

  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] elig;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] w1c;
  logic [NSRC-1:0] ack_clr;
  logic [2:0]      win;
  logic [3:0]      best;
  logic            any_elig;
  logic            ack;

  assign ack  = (state_q == REQ) && bus.inta_ack;
  assign rise = bus.src & ~prev_q;

  // Level sources use the registered sample so both kinds see the same 2-cycle latency.
  always_comb begin
    pending = '0;
    elig    = '0;
    w1c     = '0;
    ack_clr = '0;
    for (int k = 0; k < NSRC; k++) begin
      pending[k] = edge_q[k] ? pend_q[k] : prev_q[k];
      elig[k]    = pending[k] && (pri_q[k] != 4'd0);
      w1c[k]     = bus.cfg_we && (bus.cfg_addr == ADDR_PEND) && bus.cfg_wdata[k];
      ack_clr[k] = ack && (cur_q == 3'(k));
    end
  end

  // A fresh edge always beats a clear (ack or W1C) in the same cycle.
  assign pend_d = edge_q & (rise | (pend_q & ~w1c & ~ack_clr));

  // Strict '>' while scanning upwards keeps the lowest index on a tie.
  always_comb begin
    best = 4'd0;
    win  = 3'd0;
    for (int k = 0; k < NSRC; k++) begin
      if (elig[k] && (pri_q[k] > best)) begin
        best = pri_q[k];
        win  = 3'(k);
      end
    end
  end

  assign any_elig = |elig;

  always_comb begin
    rdata_d = 8'd0;
    for (int k = 0; k < NSRC; k++) begin
      if (bus.cfg_addr == 4'(k)) begin
        rdata_d = {3'b000, edge_q[k], pri_q[k]};
      end
    end
    if (bus.cfg_addr == ADDR_VBASE) rdata_d = vbase_q;
    if (bus.cfg_addr == ADDR_PEND)  rdata_d = 8'(pend_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NSRC; k++) pri_q[k] <= 4'd0;
      edge_q  <= '0;
      vbase_q <= 8'd0;
      prev_q  <= '0;
      pend_q  <= '0;
      rdata_q <= 8'd0;
    end else begin
      for (int k = 0; k < NSRC; k++) begin
        if (bus.cfg_we && (bus.cfg_addr == 4'(k))) begin
          pri_q[k]  <= bus.cfg_wdata[3:0];
          edge_q[k] <= bus.cfg_wdata[4];
        end
      end
      if (bus.cfg_we && (bus.cfg_addr == ADDR_VBASE)) vbase_q <= bus.cfg_wdata;
      prev_q  <= bus.src;
      pend_q  <= pend_d;
      rdata_q <= rdata_d;
    end
  end

  // HOLD re-arbitrates on exit, so the request is low for exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      level_q <= 4'd0;
      vec_q   <= 8'd0;
      cur_q   <= 3'd0;
    end else begin
      if ((state_q == REQ) && bus.inta_ack) begin
        state_q <= HOLD;
        req_q   <= 1'b0;
      end else if (any_elig) begin
        state_q <= REQ;
        req_q   <= 1'b1;
        level_q <= best;
        vec_q   <= vbase_q + 8'(win);
        cur_q   <= win;
      end else begin
        state_q <= IDLE;
        req_q   <= 1'b0;
      end
    end
  end

  assign bus.cfg_rdata  = rdata_q;
  assign bus.intr_req   = req_q;
  assign bus.intr_level = level_q;
  assign bus.intr_vec   = vec_q;

endmodule
`default_nettype wire

// File: tb/tb_intc_arb.sv
`default_nettype none
// ============================================================================
// tb_intc_arb : vector table, directed corner sequences and random run vs model
// Rev 1.0
// ============================================================================
module tb_intc_arb;

  localparam int NSRC = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  intc_arb_if #(.NSRC(NSRC)) bus ();

  intc_arb #(.NSRC(NSRC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural reference state
  int       m_st;   // 0 idle, 1 presenting, 2 post-ack gap
  bit [3:0] m_pri [NSRC];
  bit       m_edg [NSRC];
  bit [7:0] m_vbase;
  bit [7:0] m_pend;
  bit [7:0] m_prev;
  bit       m_req;
  bit [3:0] m_lvl;
  bit [7:0] m_vec;
  int       m_cur;
  bit [7:0] m_rd;

  typedef struct {
    logic [7:0] src;
    logic       we;
    logic [3:0] addr;
    logic [7:0] wd;
    logic       ack;
    logic       ereq;
    logic [3:0] elvl;
    logic [7:0] evec;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_vbase = 0; m_pend = 0; m_prev = 0;
    m_req = 0; m_lvl = 0; m_vec = 0; m_cur = 0; m_rd = 0;
    for (int k = 0; k < NSRC; k++) begin m_pri[k] = 0; m_edg[k] = 0; end
  endtask

  // Highest priority level first, lowest index within a level.
  function automatic int pick();
    for (int l = 15; l >= 1; l--)
      for (int k = 0; k < NSRC; k++)
        if (m_pri[k] == 4'(l) && (m_edg[k] ? m_pend[k] : m_prev[k])) return k;
    return -1;
  endfunction

  task automatic step();
    int w, a;
    bit ackn, rise, clr, we;
    bit [7:0] np, nrd, s, wd;
    w = pick();
    a = int'(bus.cfg_addr);
    we = bus.cfg_we; wd = bus.cfg_wdata; s = bus.src;
    ackn = (m_st == 1) && bus.inta_ack;
    for (int k = 0; k < NSRC; k++) begin
      rise  = s[k] && !m_prev[k];
      clr   = (we && a == 9 && wd[k]) || (ackn && m_cur == k);
      np[k] = m_edg[k] && (rise || (m_pend[k] && !clr));
    end
    if (a < NSRC)   nrd = {3'b000, m_edg[a], m_pri[a]};
    else if (a == 8) nrd = m_vbase;
    else if (a == 9) nrd = m_pend;
    else             nrd = 8'h00;
    @(posedge clk); #1;
    if (ackn) begin
      m_st = 2; m_req = 0;
    end else if (w >= 0) begin
      m_st = 1; m_req = 1; m_lvl = m_pri[w]; m_vec = m_vbase + 8'(w); m_cur = w;
    end else begin
      m_st = 0; m_req = 0;
    end
    if (we && a < NSRC) begin m_pri[a] = wd[3:0]; m_edg[a] = wd[4]; end
    if (we && a == 8) m_vbase = wd;
    m_pend = np; m_prev = s; m_rd = nrd;
    chk("model_req",   32'(bus.intr_req),   32'(m_req));
    chk("model_level", 32'(bus.intr_level), 32'(m_lvl));
    chk("model_vec",   32'(bus.intr_vec),   32'(m_vec));
    chk("model_rdata", 32'(bus.cfg_rdata),  32'(m_rd));
  endtask

  task automatic wr(input logic [3:0] addr, input logic [7:0] data);
    bus.cfg_we = 1'b1; bus.cfg_addr = addr; bus.cfg_wdata = data;
    step();
    bus.cfg_we = 1'b0; bus.cfg_wdata = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.src = '0; bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_wdata = 0; bus.inta_ack = 0;
    model_reset();

    //  src    we    addr   wd     ack   req   lvl   vec
    tbl[0]  = '{8'h00, 1'b1, 4'd2, 8'h05, 1'b0, 1'b0, 4'd0, 8'h00};
    tbl[1]  = '{8'h00, 1'b1, 4'd8, 8'h40, 1'b0, 1'b0, 4'd0, 8'h00};
    tbl[2]  = '{8'h04, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00};
    tbl[3]  = '{8'h04, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 4'd5, 8'h42};
    tbl[4]  = '{8'h04, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd5, 8'h42};
    tbl[5]  = '{8'h04, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 4'd5, 8'h42};
    tbl[6]  = '{8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 4'd5, 8'h42};
    tbl[7]  = '{8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd5, 8'h42};
    tbl[8]  = '{8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd5, 8'h42};
    tbl[9]  = '{8'h00, 1'b1, 4'd0, 8'h04, 1'b0, 1'b0, 4'd5, 8'h42};
    tbl[10] = '{8'h00, 1'b1, 4'd5, 8'h04, 1'b0, 1'b0, 4'd5, 8'h42};
    tbl[11] = '{8'h21, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd5, 8'h42};
    tbl[12] = '{8'h21, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 4'd4, 8'h40};
    tbl[13] = '{8'h21, 1'b1, 4'd5, 8'h09, 1'b0, 1'b1, 4'd4, 8'h40};
    tbl[14] = '{8'h21, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 4'd9, 8'h45};
    tbl[15] = '{8'h21, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd9, 8'h45};
    tbl[16] = '{8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 4'd9, 8'h45};
    tbl[17] = '{8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd9, 8'h45};
    tbl[18] = '{8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd9, 8'h45};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req",   32'(bus.intr_req),   0);
    chk("rst_level", 32'(bus.intr_level), 0);
    chk("rst_vec",   32'(bus.intr_vec),   0);
    chk("rst_rdata", 32'(bus.cfg_rdata),  0);
    @(negedge clk);
    rst = 1'b0;

    // Level source latency/hold gap, tie break and priority change
    for (int i = 0; i < 19; i++) begin
      bus.src = tbl[i].src; bus.cfg_we = tbl[i].we; bus.cfg_addr = tbl[i].addr;
      bus.cfg_wdata = tbl[i].wd; bus.inta_ack = tbl[i].ack;
      step();
      chk($sformatf("tbl%0d_req", i),   32'(bus.intr_req),   32'(tbl[i].ereq));
      chk($sformatf("tbl%0d_level", i), 32'(bus.intr_level), 32'(tbl[i].elvl));
      chk($sformatf("tbl%0d_vec", i),   32'(bus.intr_vec),   32'(tbl[i].evec));
    end
    bus.cfg_we = 0; bus.inta_ack = 0; bus.src = '0; bus.cfg_addr = 0;

    // Edge source: ack clears, new edge in the ack cycle survives
    do_reset();
    wr(4'd1, 8'h13);
    bus.src = 8'h02; step();
    bus.src = 8'h00; step();
    chk("edge_req", 32'(bus.intr_req), 1);
    chk("edge_vec", 32'(bus.intr_vec), 32'h01);
    bus.inta_ack = 1; step();
    bus.inta_ack = 0; bus.cfg_addr = 4'd9; step();
    chk("edge_cleared_req", 32'(bus.intr_req), 0);
    chk("edge_pend_rd", 32'(bus.cfg_rdata), 0);
    step();
    chk("edge_stays_low", 32'(bus.intr_req), 0);
    bus.src = 8'h02; step();
    bus.src = 8'h00; step();
    bus.src = 8'h02; bus.inta_ack = 1; step();
    chk("edge_hold_gap", 32'(bus.intr_req), 0);
    bus.src = 8'h00; bus.inta_ack = 0; step();
    chk("edge_reassert", 32'(bus.intr_req), 1);
    bus.inta_ack = 1; step();
    bus.inta_ack = 0; step();

    // Preemption by a higher-priority edge; ack only retires the winner
    wr(4'd3, 8'h12);
    wr(4'd6, 8'h17);
    wr(4'd8, 8'h10);
    bus.src = 8'h08; step();
    bus.src = 8'h00; step();
    chk("pre_vec3", 32'(bus.intr_vec), 32'h13);
    bus.src = 8'h40; step();
    chk("pre_vec3_hold", 32'(bus.intr_vec), 32'h13);
    bus.src = 8'h00; step();
    chk("pre_vec6", 32'(bus.intr_vec), 32'h16);
    chk("pre_lvl6", 32'(bus.intr_level), 7);
    bus.inta_ack = 1; step();
    bus.inta_ack = 0; bus.cfg_addr = 4'd9; step();
    chk("pre_back_to3", 32'(bus.intr_vec), 32'h13);
    chk("pre_req3", 32'(bus.intr_req), 1);
    chk("pre_pend3", 32'(bus.cfg_rdata), 32'h08);
    wr(4'd9, 8'h08);
    step();
    chk("w1c_idle", 32'(bus.intr_req), 0);

    // Async reset while presenting
    bus.src = 8'h08; step();
    bus.src = 8'h00; step();
    chk("pre_rst_req", 32'(bus.intr_req), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req", 32'(bus.intr_req), 0);
    chk("async_rst_vec", 32'(bus.intr_vec), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 10; a++) begin
      bus.cfg_addr = 4'(a);
      step();
      chk($sformatf("rst_rd%0d", a), 32'(bus.cfg_rdata), 0);
    end
    // Masked sources never request
    bus.src = 8'hFF;
    repeat (4) begin
      step();
      chk("masked_req", 32'(bus.intr_req), 0);
    end

    // Random traffic against the model
    bus.src = 8'h00;
    wr(4'd8, 8'($urandom));
    for (int k = 0; k < NSRC; k++) wr(4'(k), 8'($urandom_range(0, 31)));
    for (int i = 0; i < 600; i++) begin
      bus.src      = bus.src ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      bus.inta_ack = ($urandom_range(0, 2) == 0);
      bus.cfg_addr = 4'($urandom_range(0, 15));
      bus.cfg_we   = ($urandom_range(0, 9) == 0);
      bus.cfg_wdata = 8'($urandom);
      step();
    end
    bus.cfg_we = 0; bus.inta_ack = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
